// File: rtl/chan_ro_sched_pkg.sv
// Shared definitions for the channel readout scheduler:
// FSM state encodings and the header word layout.
package chan_ro_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_READOUT = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    // Header word: {HDR_TAG, channel (HDR_CH_W bits), event length}
    localparam logic [1:0] HDR_TAG  = 2'b10;
    localparam int         HDR_CH_W = 4;

endpackage

// File: rtl/chan_ro_sched_rr_pick.sv
// Rotating priority encoder: first requester strictly after 'last',
// wrapping modulo NCH, so 'last' itself has the lowest priority.
module rr_pick #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] last,
    output logic [CHW-1:0] gnt_idx,
    output logic           gnt_vld
);

    logic [CHW-1:0] idx;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CHW'((int'(last) + k) % NCH);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/chan_ro_sched.sv
// Round-robin readout scheduler: grants one channel holding a complete
// event, writes a header word, then streams EVT_LEN samples under backpressure.
module chan_ro_sched
    import chan_ro_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CHW   = 2,
    parameter int LEN_W = 10,
    parameter int DW    = 6 + LEN_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    CH_AVAIL,
    input  logic [NCH*DW-1:0] CH_DATA,
    output logic [NCH-1:0]    CH_RDREQ,
    input  logic [LEN_W-1:0]  EVT_LEN,
    input  logic              OUT_FULL,
    output logic              OUT_WR,
    output logic [DW-1:0]     OUT_DATA,
    output logic [CHW-1:0]    CUR_CH,
    output logic              BUSY,
    output logic              EVT_DONE
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [CHW-1:0]   cur_ch_q, cur_ch_d;
    logic [CHW-1:0]   rr_last_q, rr_last_d;
    logic             out_wr_q, out_wr_d;
    logic [DW-1:0]    out_data_q, out_data_d;

    logic [CHW-1:0]   gnt_idx;
    logic             gnt_vld;
    logic             rd_en;
    logic [DW-1:0]    ch_word;
    logic [DW-1:0]    hdr_word;

    rr_pick #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_rr_pick (
        .req     (CH_AVAIL),
        .last    (rr_last_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign ch_word  = CH_DATA[int'(cur_ch_q)*DW +: DW];
    assign hdr_word = DW'({HDR_TAG, HDR_CH_W'(cur_ch_q), cnt_q});
    assign rd_en    = (state_q == S_READOUT) && !OUT_FULL && (cnt_q != '0);

    always_comb begin
        CH_RDREQ = '0;
        if (rd_en) CH_RDREQ[cur_ch_q] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_ch_d   = cur_ch_q;
        rr_last_d  = rr_last_q;
        out_wr_d   = 1'b0;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    cur_ch_d = gnt_idx;
                    cnt_d    = EVT_LEN;
                    state_d  = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!OUT_FULL) begin
                    out_wr_d   = 1'b1;
                    out_data_d = hdr_word;
                    state_d    = (cnt_q == '0) ? S_DONE : S_READOUT;
                end
            end
            S_READOUT: begin
                if (rd_en) begin
                    out_wr_d   = 1'b1;
                    out_data_d = ch_word;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Served channel drops to lowest priority for the next pick
                rr_last_d = cur_ch_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_ch_q   <= '0;
            rr_last_q  <= CHW'(NCH - 1);
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_ch_q   <= cur_ch_d;
            rr_last_q  <= rr_last_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
        end
    end

    assign OUT_WR   = out_wr_q;
    assign OUT_DATA = out_data_q;
    assign CUR_CH   = cur_ch_q;
    assign BUSY     = (state_q != S_IDLE);
    assign EVT_DONE = (state_q == S_DONE);

endmodule
